// File: rtl/ysyx_25030093_wbu.sv
// Writeback/commit unit.
// Takes one retiring instruction at a time from execute and performs its GPR
// and/or CSR write. For ecall it writes mepc and then mcause. It then hands the
// redirect PC to fetch and counts the retired instruction on that handshake.
// Every strobe and every data output is a flop. Each strobe is high only in the
// cycle that follows the edge that scheduled it.
module ysyx_25030093_wbu #(
    parameter int unsigned               ADDR_WIDTH  = 5,
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]     ECALL_CAUSE = DATA_WIDTH'(11)
) (
    input  logic                  clk,
    input  logic                  rst,
    // retiring instruction from execute
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_next_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0] in_rd_wdata,
    input  logic                  in_rd_wen,
    input  logic [11:0]           in_csr_addr,
    input  logic [DATA_WIDTH-1:0] in_csr_wdata,
    input  logic                  in_csr_wen,
    input  logic                  in_ecall,
    input  logic                  in_mret,
    // current trap CSRs
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    // GPR write port
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wen,
    // CSR write port
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_wen,
    // redirect to fetch
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] retire_cnt
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_COMMIT     = 3'd1;
    localparam logic [2:0] ST_TRAP_EPC   = 3'd2;
    localparam logic [2:0] ST_TRAP_CAUSE = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    logic [2:0]            state_r;
    logic [2:0]            state_nx_s;
    logic                  in_ready_r;
    logic [DATA_WIDTH-1:0] next_pc_r;
    logic                  mret_r;

    logic [ADDR_WIDTH-1:0] rf_waddr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;
    logic                  rf_wen_r;
    logic [11:0]           csr_waddr_r;
    logic [DATA_WIDTH-1:0] csr_wdata_r;
    logic                  csr_wen_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_pc_r;
    logic [DATA_WIDTH-1:0] retire_cnt_r;

    logic                  accept_s;
    logic                  redirect_hs_s;
    logic                  gpr_write_s;

    // Handshake decodes and the GPR-write qualifier (x0 is never written, ecall suppresses it).
    always_comb begin
        accept_s      = in_valid & in_ready_r & (state_r == ST_IDLE);
        redirect_hs_s = (state_r == ST_DONE) & out_valid_r & out_ready;
        gpr_write_s   = in_rd_wen & ~in_ecall & (in_rd_addr != '0);
    end

    // Next-state logic for the commit sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (in_ecall) begin
                        state_nx_s = ST_TRAP_EPC;
                    end else begin
                        state_nx_s = ST_COMMIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_COMMIT:     state_nx_s = ST_DONE;
            ST_TRAP_EPC:   state_nx_s = ST_TRAP_CAUSE;
            ST_TRAP_CAUSE: state_nx_s = ST_DONE;
            ST_DONE: begin
                if (redirect_hs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default:       state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // in_ready is a flop that is high exactly while the sequencer sits in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_nx_s == ST_IDLE);
        end
    end

    // Capture the fields that the redirect computation needs after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_pc_r <= '0;
            mret_r    <= 1'b0;
        end else if (accept_s) begin
            next_pc_r <= in_next_pc;
            mret_r    <= in_mret;
        end else begin
            next_pc_r <= next_pc_r;
            mret_r    <= mret_r;
        end
    end

    // GPR write port: one strobe cycle, scheduled on the accept edge so it lands in COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
        end else if (accept_s && gpr_write_s) begin
            rf_wen_r   <= 1'b1;
            rf_waddr_r <= in_rd_addr;
            rf_wdata_r <= in_rd_wdata;
        end else begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
        end
    end

    // CSR write port: user CSR write in COMMIT, or mepc in TRAP_EPC followed by mcause in TRAP_CAUSE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csr_wen_r   <= 1'b0;
            csr_waddr_r <= '0;
            csr_wdata_r <= '0;
        end else if (accept_s && in_ecall) begin
            csr_wen_r   <= 1'b1;
            csr_waddr_r <= CSR_MEPC;
            csr_wdata_r <= in_pc;
        end else if (accept_s && in_csr_wen) begin
            csr_wen_r   <= 1'b1;
            csr_waddr_r <= in_csr_addr;
            csr_wdata_r <= in_csr_wdata;
        end else if (state_r == ST_TRAP_EPC) begin
            csr_wen_r   <= 1'b1;
            csr_waddr_r <= CSR_MCAUSE;
            csr_wdata_r <= ECALL_CAUSE;
        end else begin
            csr_wen_r   <= 1'b0;
            csr_waddr_r <= '0;
            csr_wdata_r <= '0;
        end
    end

    // Redirect PC: chosen at the end of COMMIT / TRAP_CAUSE, then held until fetch takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= '0;
        end else if (state_r == ST_COMMIT) begin
            out_valid_r <= 1'b1;
            if (mret_r) begin
                out_pc_r <= csr_mepc;
            end else begin
                out_pc_r <= next_pc_r;
            end
        end else if (state_r == ST_TRAP_CAUSE) begin
            out_valid_r <= 1'b1;
            out_pc_r    <= csr_mtvec;
        end else if (redirect_hs_s) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= out_pc_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_pc_r    <= out_pc_r;
        end
    end

    // Retired-instruction counter. It steps on the redirect handshake and wraps modulo 2^DATA_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_r <= '0;
        end else if (redirect_hs_s) begin
            retire_cnt_r <= retire_cnt_r + DATA_WIDTH'(1);
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;
    assign rf_wen     = rf_wen_r;
    assign csr_waddr  = csr_waddr_r;
    assign csr_wdata  = csr_wdata_r;
    assign csr_wen    = csr_wen_r;
    assign out_valid  = out_valid_r;
    assign out_pc     = out_pc_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Scoreboard bench for ysyx_25030093_wbu.
// The driver works out each instruction's expected effects (register writes and
// the redirect) and pushes them onto queues. A monitor pops those queues and
// compares them with the DUT outputs whenever a strobe or the redirect appears.
module tb_ysyx_25030093_wbu;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_next_pc, in_rd_wdata, in_csr_wdata;
    logic [4:0]  in_rd_addr;
    logic        in_rd_wen, in_csr_wen, in_ecall, in_mret;
    logic [11:0] in_csr_addr;
    logic [31:0] csr_mtvec, csr_mepc;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, retire_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_retire = 0;
    bit ready_rand = 1'b0;
    bit ready_fixed = 1'b1;

    wr_t rf_q[$];
    wr_t csr_q[$];
    rd_t pc_q[$];

    ysyx_25030093_wbu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_next_pc(in_next_pc),
        .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata), .in_rd_wen(in_rd_wen),
        .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata), .in_csr_wen(in_csr_wen),
        .in_ecall(in_ecall), .in_mret(in_mret),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // cycle counter, advanced on every active edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // fetch-side ready, changed well away from both clock edges
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_fixed;
        end
    end

    // monitor: pops the expected effects and compares them with the DUT outputs on the falling edge
    initial begin
        bit          prev_hold;
        bit          prev_ov;
        logic [31:0] prev_pc;
        wr_t         e;
        rd_t         r;
        prev_hold = 1'b0;
        prev_ov   = 1'b0;
        prev_pc   = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
                prev_ov   = 1'b0;
            end else begin
                if (rf_wen) begin
                    if (rf_q.size() == 0) begin
                        fail_now("rf_spurious_write");
                    end else begin
                        e = rf_q.pop_front();
                        chk("rf_waddr", {59'd0, rf_waddr}, {52'd0, e.addr});
                        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
                        chk("rf_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (csr_wen) begin
                    if (csr_q.size() == 0) begin
                        fail_now("csr_spurious_write");
                    end else begin
                        e = csr_q.pop_front();
                        chk("csr_waddr", {52'd0, csr_waddr}, {52'd0, e.addr});
                        chk("csr_wdata", {32'd0, csr_wdata}, {32'd0, e.data});
                        chk("csr_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (out_valid && !prev_ov) begin
                    if (pc_q.size() == 0) begin
                        fail_now("out_valid_spurious");
                    end else begin
                        r = pc_q.pop_front();
                        chk("out_pc", {32'd0, out_pc}, {32'd0, r.pc});
                        chk("out_valid_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end
                if (prev_hold) begin
                    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
                    chk("hold_out_pc", {32'd0, out_pc}, {32'd0, prev_pc});
                end
                if (out_valid) begin
                    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
                    chk("strobes_in_done", {62'd0, rf_wen, csr_wen}, 64'd0);
                end
                if (out_valid && out_ready) begin
                    chk("retire_cnt", {32'd0, retire_cnt}, 64'(exp_retire));
                    exp_retire++;
                end
                prev_hold = out_valid && !out_ready;
                prev_pc   = out_pc;
                prev_ov   = out_valid;
            end
        end
    end

    // Present one instruction once the WBU is idle. When track is set, push the
    // effects that the architectural rules require for it.
    task automatic issue(input bit track,
                         input logic [31:0] pc, input logic [31:0] npc,
                         input logic [4:0] rd, input logic [31:0] rdw, input bit rdwen,
                         input logic [11:0] ca, input logic [31:0] cw, input bit cwen,
                         input bit ec, input bit mr,
                         input logic [31:0] tvec, input logic [31:0] epc);
        int  n;
        int  k;
        wr_t w;
        rd_t r;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            return;
        end
        in_pc = pc; in_next_pc = npc; in_rd_addr = rd; in_rd_wdata = rdw; in_rd_wen = rdwen;
        in_csr_addr = ca; in_csr_wdata = cw; in_csr_wen = cwen; in_ecall = ec; in_mret = mr;
        csr_mtvec = tvec; csr_mepc = epc;
        in_valid = 1'b1;
        k = cyc;
        if (track) begin
            if (ec) begin
                w.addr = 12'h341; w.data = pc;    w.cyc = k + 1; csr_q.push_back(w);
                w.addr = 12'h342; w.data = 32'd11; w.cyc = k + 2; csr_q.push_back(w);
                r.pc = tvec; r.cyc = k + 3; pc_q.push_back(r);
            end else begin
                if (rdwen && rd != 5'd0) begin
                    w.addr = {7'd0, rd}; w.data = rdw; w.cyc = k + 1; rf_q.push_back(w);
                end
                if (cwen) begin
                    w.addr = ca; w.data = cw; w.cyc = k + 1; csr_q.push_back(w);
                end
                r.pc = mr ? epc : npc; r.cyc = k + 2; pc_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pc = $urandom; in_next_pc = $urandom; in_rd_addr = 5'($urandom);
        in_rd_wdata = $urandom; in_rd_wen = 1'($urandom); in_csr_addr = 12'($urandom);
        in_csr_wdata = $urandom; in_csr_wen = 1'($urandom);
        in_ecall = 1'($urandom); in_mret = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_rf"}, {26'd0, rf_wen, rf_waddr, rf_wdata}, 64'd0);
        chk({tag, "_csr"}, {19'd0, csr_wen, csr_waddr, csr_wdata}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_pc"}, {32'd0, out_pc}, 64'd0);
        chk({tag, "_retire_cnt"}, {32'd0, retire_cnt}, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pc_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
    endtask

    initial begin
        logic [11:0] csr_set[4];
        logic [31:0] rpc;
        int n;
        csr_set[0] = 12'h300; csr_set[1] = 12'h305; csr_set[2] = 12'h341; csr_set[3] = 12'h342;
        in_valid = 1'b0; in_pc = 32'd0; in_next_pc = 32'd0; in_rd_addr = 5'd0; in_rd_wdata = 32'd0;
        in_rd_wen = 1'b0; in_csr_addr = 12'd0; in_csr_wdata = 32'd0; in_csr_wen = 1'b0;
        in_ecall = 1'b0; in_mret = 1'b0; csr_mtvec = 32'd0; csr_mepc = 32'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // addi x5
        issue(1'b1, 32'h80000000, 32'h80000004, 5'd5, 32'h1234, 1'b1, 12'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        // write to x0 is dropped
        issue(1'b1, 32'h80000004, 32'h80000008, 5'd0, 32'hdead, 1'b1, 12'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        // ecall
        issue(1'b1, 32'h80000010, 32'h80000014, 5'd7, 32'h55, 1'b1, 12'h305, 32'h77, 1'b1, 1'b1, 1'b1, 32'h80000100, 32'h0);
        // mret with rd write
        issue(1'b1, 32'h80000100, 32'h80000104, 5'd9, 32'h99, 1'b1, 12'h300, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80000100, 32'h80000014);
        // csrw mtvec
        issue(1'b1, 32'h80000018, 32'h8000001c, 5'd0, 32'h0, 1'b0, 12'h305, 32'h80000200, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();

        // fetch stalls for several cycles while the redirect is held
        ready_fixed = 1'b0;
        issue(1'b1, 32'h80000020, 32'h80000024, 5'd3, 32'h33, 1'b1, 12'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("stall_out_valid_timeout");
        repeat (5) @(negedge clk);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_pc", {32'd0, out_pc}, 64'h80000024);
        ready_fixed = 1'b1;
        drain();

        // reset arriving while the mepc write is on the port
        issue(1'b0, 32'h80000030, 32'h80000034, 5'd1, 32'h1, 1'b0, 12'h300, 32'd0, 1'b0, 1'b1, 1'b0, 32'h80000100, 32'h0);
        chk("trap_epc_wen", {63'd0, csr_wen}, 64'd1);
        chk("trap_epc_addr", {52'd0, csr_waddr}, 64'h341);
        chk("trap_epc_data", {32'd0, csr_wdata}, 64'h80000030);
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_retire = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 32'h80000000, 32'h80000004, 5'd5, 32'h1234, 1'b1, 12'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();

        // random traffic with random fetch back-pressure
        ready_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            rpc = $urandom & 32'hfffffffc;
            issue(1'b1, rpc, rpc + 32'd4, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0),
                  csr_set[$urandom_range(0, 3)], $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  $urandom & 32'hfffffffc, $urandom & 32'hfffffffc);
        end
        drain();
        ready_rand = 1'b0;
        repeat (3) @(negedge clk);

        chk("rf_queue_empty", 64'(rf_q.size()), 64'd0);
        chk("csr_queue_empty", 64'(csr_q.size()), 64'd0);
        chk("pc_queue_empty", 64'(pc_q.size()), 64'd0);
        chk("final_retire_cnt", {32'd0, retire_cnt}, 64'(exp_retire));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
